// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM state
// encodings, arbitration mode selectors, default read latency.
package bus_arbiter_pkg;

    localparam int ARB_RR     = 0;
    localparam int ARB_FIXED  = 1;
    localparam int ARB_RD_LAT = 1;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arbState_e;

    function automatic logic [1:0] oneHot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of both master request/response ports and the single upstream
// mem_bus port; the arbiter takes the slave view, the environment the master view.
interface bus_arbiter_if;

    logic [31:0] m0_addr_i;
    logic        m0_rstrb_i;
    logic [3:0]  m0_wmask_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;

    logic [31:0] m1_addr_i;
    logic        m1_rstrb_i;
    logic [3:0]  m1_wmask_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;

    logic [31:0] s_addr_o;
    logic        s_rstrb_o;
    logic [3:0]  s_wmask_o;
    logic [31:0] s_wdata_o;
    logic [31:0] s_rdata_i;

    modport slave (
        input  m0_addr_i, m0_rstrb_i, m0_wmask_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_addr_i, m1_rstrb_i, m1_wmask_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output s_addr_o, s_rstrb_o, s_wmask_o, s_wdata_o,
        input  s_rdata_i
    );

    modport master (
        output m0_addr_i, m0_rstrb_i, m0_wmask_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_addr_i, m1_rstrb_i, m1_wmask_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  s_addr_o, s_rstrb_o, s_wmask_o, s_wdata_o,
        output s_rdata_i
    );

endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin on a 1-bit last-winner register, or
// fixed priority with master 0 winning.
module rr_arb2
    import bus_arbiter_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       winner_o
);

    logic last_q;
    logic last_d;
    logic winner;
    logic anyGnt;

    always_comb begin
        winner = 1'b0;
        if (req_i == 2'b11) begin
            winner = (ARB_MODE == ARB_FIXED) ? 1'b0 : ~last_q;
        end else begin
            winner = req_i[1];
        end
        anyGnt = en_i && (req_i != 2'b00);
        gnt_o  = anyGnt ? oneHot2(winner) : 2'b00;
        last_d = anyGnt ? winner : last_q;
    end

    // Reset to master 1 so that master 0 wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign winner_o = winner;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter/sequencer for mem_bus: one transfer per grant, writes
// finish in the grant cycle, reads return RD_LAT (1..15) cycles later.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int RD_LAT   = ARB_RD_LAT,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    arbState_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic [1:0]  rvalid_q, rvalid_d;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        winner;
    logic        eligible;
    logic        readGnt;

    logic [31:0] sAddr;
    logic        sRstrb;
    logic [3:0]  sWmask;
    logic [31:0] sWdata;

    assign req[0] = bus.m0_rstrb_i | (|bus.m0_wmask_i);
    assign req[1] = bus.m1_rstrb_i | (|bus.m1_wmask_i);

    // The read-completion cycle is also a grant cycle, so reads pipeline back to back.
    assign eligible = !rst && ((state_q == ARB_IDLE) || (cnt_q == 4'd0));

    rr_arb2 #(
        .ARB_MODE (ARB_MODE)
    ) uArb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .en_i     (eligible),
        .gnt_o    (gnt),
        .winner_o (winner)
    );

    // A request carrying both rstrb and a write mask is forwarded as a write only.
    always_comb begin
        sAddr  = 32'd0;
        sRstrb = 1'b0;
        sWmask = 4'd0;
        sWdata = 32'd0;
        if (gnt[0]) begin
            sAddr  = bus.m0_addr_i;
            sRstrb = bus.m0_rstrb_i && (bus.m0_wmask_i == 4'd0);
            sWmask = bus.m0_wmask_i;
            sWdata = bus.m0_wdata_i;
        end else if (gnt[1]) begin
            sAddr  = bus.m1_addr_i;
            sRstrb = bus.m1_rstrb_i && (bus.m1_wmask_i == 4'd0);
            sWmask = bus.m1_wmask_i;
            sWdata = bus.m1_wdata_i;
        end
    end

    assign readGnt = sRstrb;

    // rvalid is registered one cycle ahead of the completion cycle it marks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        rvalid_d = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                state_d = ARB_IDLE;
            end
            ARB_RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rvalid_d = oneHot2(owner_q);
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (readGnt) begin
            state_d = ARB_RD_WAIT;
            cnt_d   = LAT_M1;
            owner_d = winner;
            if (LAT_M1 == 4'd0) begin
                rvalid_d = oneHot2(winner);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.m0_gnt_o    = gnt[0];
    assign bus.m1_gnt_o    = gnt[1];
    assign bus.m0_rvalid_o = rvalid_q[0];
    assign bus.m1_rvalid_o = rvalid_q[1];
    assign bus.m0_rdata_o  = bus.s_rdata_i;
    assign bus.m1_rdata_o  = bus.s_rdata_i;
    assign bus.s_addr_o    = sAddr;
    assign bus.s_rstrb_o   = sRstrb;
    assign bus.s_wmask_o   = sWmask;
    assign bus.s_wdata_o   = sWdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: four instances cover RD_LAT 1/3/4 and both
// arbitration modes; instance L1 sits in front of a small byte-masked memory.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    bus_arbiter_if busL1 ();
    bus_arbiter_if busL3 ();
    bus_arbiter_if busFx ();
    bus_arbiter_if busL4 ();

    bus_arbiter #(.RD_LAT(1), .ARB_MODE(ARB_RR))    dutL1 (.clk(clk), .rst(rst), .bus(busL1));
    bus_arbiter #(.RD_LAT(3), .ARB_MODE(ARB_RR))    dutL3 (.clk(clk), .rst(rst), .bus(busL3));
    bus_arbiter #(.RD_LAT(1), .ARB_MODE(ARB_FIXED)) dutFx (.clk(clk), .rst(rst), .bus(busFx));
    bus_arbiter #(.RD_LAT(4), .ARB_MODE(ARB_RR))    dutL4 (.clk(clk), .rst(rst), .bus(busL4));

    always #5 clk = ~clk;

    // One-cycle-latency memory behind instance L1.
    logic [31:0] mem [0:255];
    logic [31:0] memRdata_q = 32'd0;

    always @(posedge clk) begin
        if (busL1.s_rstrb_o) begin
            memRdata_q <= mem[busL1.s_addr_o[9:2]];
        end
        for (int b = 0; b < 4; b++) begin
            if (busL1.s_wmask_o[b]) begin
                mem[busL1.s_addr_o[9:2]][8*b +: 8] <= busL1.s_wdata_o[8*b +: 8];
            end
        end
    end

    assign busL1.s_rdata_i = memRdata_q;
    assign busL3.s_rdata_i = 32'h3333_0003;
    assign busFx.s_rdata_i = 32'hF1F1_0001;
    assign busL4.s_rdata_i = 32'h4444_0004;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        busL1.m0_addr_i = '0; busL1.m0_rstrb_i = 1'b0; busL1.m0_wmask_i = '0; busL1.m0_wdata_i = '0;
        busL1.m1_addr_i = '0; busL1.m1_rstrb_i = 1'b0; busL1.m1_wmask_i = '0; busL1.m1_wdata_i = '0;
        busL3.m0_addr_i = '0; busL3.m0_rstrb_i = 1'b0; busL3.m0_wmask_i = '0; busL3.m0_wdata_i = '0;
        busL3.m1_addr_i = '0; busL3.m1_rstrb_i = 1'b0; busL3.m1_wmask_i = '0; busL3.m1_wdata_i = '0;
        busFx.m0_addr_i = '0; busFx.m0_rstrb_i = 1'b0; busFx.m0_wmask_i = '0; busFx.m0_wdata_i = '0;
        busFx.m1_addr_i = '0; busFx.m1_rstrb_i = 1'b0; busFx.m1_wmask_i = '0; busFx.m1_wdata_i = '0;
        busL4.m0_addr_i = '0; busL4.m0_rstrb_i = 1'b0; busL4.m0_wmask_i = '0; busL4.m0_wdata_i = '0;
        busL4.m1_addr_i = '0; busL4.m1_rstrb_i = 1'b0; busL4.m1_wmask_i = '0; busL4.m1_wdata_i = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [73:0] got;
        rst = 1'b1;
        clearInputs();
        nextCycle();
        nextCycle();
        #1;
        got = {busL1.m0_gnt_o, busL1.m1_gnt_o, busL1.m0_rvalid_o, busL1.m1_rvalid_o,
               busL1.s_rstrb_o, busL1.s_wmask_o, busL1.s_addr_o, busL1.s_wdata_o};
        total++;
        if (got !== 74'd0) begin
            bad++;
            $display("[TB] FAIL reset_L1: got %h want 0", got);
        end
        got = {busL4.m0_gnt_o, busL4.m1_gnt_o, busL4.m0_rvalid_o, busL4.m1_rvalid_o,
               busL4.s_rstrb_o, busL4.s_wmask_o, busL4.s_addr_o, busL4.s_wdata_o};
        total++;
        if (got !== 74'd0) begin
            bad++;
            $display("[TB] FAIL reset_L4: got %h want 0", got);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_readback();
        logic [6:0] got;
        logic [2:0] got3;
        logic [1:0] rv;
        doReset();
        busL1.m0_wmask_i = 4'hF;
        busL1.m0_addr_i  = 32'h0000_0100;
        busL1.m0_wdata_i = 32'hDEAD_BEEF;
        #1;
        got = {busL1.m0_gnt_o, busL1.m1_gnt_o, busL1.s_wmask_o, busL1.s_rstrb_o};
        total++;
        if (got !== {2'b10, 4'hF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wr_grant: got %b want %b", got, {2'b10, 4'hF, 1'b0});
        end
        total++;
        if ({busL1.s_addr_o, busL1.s_wdata_o} !== {32'h0000_0100, 32'hDEAD_BEEF}) begin
            bad++;
            $display("[TB] FAIL wr_bus: got addr %h data %h want 00000100 deadbeef",
                     busL1.s_addr_o, busL1.s_wdata_o);
        end
        nextCycle();
        busL1.m0_wmask_i = 4'h0;
        busL1.m0_rstrb_i = 1'b1;
        #1;
        got3 = {busL1.m0_gnt_o, busL1.s_rstrb_o, busL1.m0_rvalid_o};
        total++;
        if (got3 !== 3'b110) begin
            bad++;
            $display("[TB] FAIL rd_grant: got %b want 110", got3);
        end
        nextCycle();
        busL1.m0_rstrb_i = 1'b0;
        #1;
        rv = {busL1.m0_rvalid_o, busL1.m1_rvalid_o};
        total++;
        if (rv !== 2'b10) begin
            bad++;
            $display("[TB] FAIL rd_valid: got %b want 10", rv);
        end
        total++;
        if (busL1.m0_rdata_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL rd_data: got %h want deadbeef", busL1.m0_rdata_o);
        end
        nextCycle();
        #1;
        rv = {busL1.m0_rvalid_o, busL1.m1_rvalid_o};
        total++;
        if (rv !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rd_valid_end: got %b want 00", rv);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  expTab  [5] = '{4'b1000, 4'b0110, 4'b1001, 4'b0110, 4'b0001};
        logic [31:0] addrTab [5] = '{32'h10, 32'h20, 32'h10, 32'h20, 32'h0};
        logic [3:0]  got;
        doReset();
        busL1.m0_rstrb_i = 1'b1;
        busL1.m0_addr_i  = 32'h10;
        busL1.m1_rstrb_i = 1'b1;
        busL1.m1_addr_i  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                busL1.m0_rstrb_i = 1'b0;
                busL1.m1_rstrb_i = 1'b0;
            end
            #1;
            got = {busL1.m0_gnt_o, busL1.m1_gnt_o, busL1.m0_rvalid_o, busL1.m1_rvalid_o};
            total++;
            if (got !== expTab[i]) begin
                bad++;
                $display("[TB] FAIL rr_cycle%0d: got gnt/rv %b want %b", i, got, expTab[i]);
            end
            total++;
            if (busL1.s_addr_o !== addrTab[i]) begin
                bad++;
                $display("[TB] FAIL rr_addr%0d: got %h want %h", i, busL1.s_addr_o, addrTab[i]);
            end
            nextCycle();
        end
    endtask

    task automatic test_latency3();
        logic [4:0] got;
        doReset();
        busL3.m1_rstrb_i = 1'b1;
        busL3.m1_addr_i  = 32'h40;
        #1;
        got = {busL3.m0_gnt_o, busL3.m1_gnt_o, busL3.m0_rvalid_o, busL3.m1_rvalid_o, busL3.s_rstrb_o};
        total++;
        if (got !== 5'b01001) begin
            bad++;
            $display("[TB] FAIL l3_rd_grant: got %b want 01001", got);
        end
        nextCycle();
        busL3.m1_rstrb_i = 1'b0;
        busL3.m0_wmask_i = 4'h1;
        busL3.m0_addr_i  = 32'h44;
        busL3.m0_wdata_i = 32'h11;
        for (int i = 1; i < 3; i++) begin
            #1;
            got = {busL3.m0_gnt_o, busL3.m1_gnt_o, busL3.m0_rvalid_o, busL3.m1_rvalid_o, |busL3.s_wmask_o};
            total++;
            if (got !== 5'b00000) begin
                bad++;
                $display("[TB] FAIL l3_wait_T%0d: got %b want 00000", i, got);
            end
            nextCycle();
        end
        #1;
        got = {busL3.m0_gnt_o, busL3.m1_gnt_o, busL3.m0_rvalid_o, busL3.m1_rvalid_o, |busL3.s_wmask_o};
        total++;
        if (got !== 5'b10011 || busL3.s_wmask_o !== 4'h1) begin
            bad++;
            $display("[TB] FAIL l3_complete: got %b mask %h want 10011 mask 1", got, busL3.s_wmask_o);
        end
        nextCycle();
        busL3.m0_wmask_i = 4'h0;
        #1;
        got = {busL3.m0_gnt_o, busL3.m1_gnt_o, busL3.m0_rvalid_o, busL3.m1_rvalid_o, |busL3.s_wmask_o};
        total++;
        if (got !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL l3_after: got %b want 00000", got);
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] got;
        doReset();
        busFx.m0_wmask_i = 4'hF;
        busFx.m0_addr_i  = 32'h200;
        busFx.m1_wmask_i = 4'hF;
        busFx.m1_addr_i  = 32'h300;
        for (int i = 0; i < 4; i++) begin
            #1;
            got = {busFx.m0_gnt_o, busFx.m1_gnt_o};
            total++;
            if (got !== 2'b10) begin
                bad++;
                $display("[TB] FAIL fix_cycle%0d: got gnt %b want 10", i, got);
            end
            nextCycle();
        end
        busFx.m0_wmask_i = 4'h0;
        #1;
        got = {busFx.m0_gnt_o, busFx.m1_gnt_o};
        total++;
        if (got !== 2'b01 || busFx.s_addr_o !== 32'h300) begin
            bad++;
            $display("[TB] FAIL fix_m1_alone: got gnt %b addr %h want 01 addr 300", got, busFx.s_addr_o);
        end
        busFx.m1_wmask_i = 4'h0;
    endtask

    task automatic test_reset_mid_read();
        logic [3:0]  got;
        logic [73:0] all;
        doReset();
        busL4.m0_rstrb_i = 1'b1;
        busL4.m0_addr_i  = 32'h80;
        #1;
        got = {busL4.m0_gnt_o, busL4.m1_gnt_o, busL4.m0_rvalid_o, busL4.m1_rvalid_o};
        total++;
        if (got !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL mid_grant: got %b want 1000", got);
        end
        nextCycle();
        busL4.m0_rstrb_i = 1'b0;
        nextCycle();
        rst = 1'b1;
        busL4.m1_rstrb_i = 1'b1;
        busL4.m1_addr_i  = 32'h90;
        nextCycle();
        #1;
        all = {busL4.m0_gnt_o, busL4.m1_gnt_o, busL4.m0_rvalid_o, busL4.m1_rvalid_o,
               busL4.s_rstrb_o, busL4.s_wmask_o, busL4.s_addr_o, busL4.s_wdata_o};
        total++;
        if (all !== 74'd0) begin
            bad++;
            $display("[TB] FAIL mid_in_reset: got %h want 0", all);
        end
        nextCycle();
        rst = 1'b0;
        #1;
        got = {busL4.m0_gnt_o, busL4.m1_gnt_o, busL4.m0_rvalid_o, busL4.m1_rvalid_o};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL mid_regrant: got %b want 0100", got);
        end
        nextCycle();
        busL4.m1_rstrb_i = 1'b0;
        for (int i = 1; i < 6; i++) begin
            #1;
            got = {busL4.m0_gnt_o, busL4.m1_gnt_o, busL4.m0_rvalid_o, busL4.m1_rvalid_o};
            total++;
            if (got !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("[TB] FAIL mid_tail%0d: got %b want %b", i, got,
                         (i == 4) ? 4'b0001 : 4'b0000);
            end
            nextCycle();
        end
    endtask

    task automatic test_illegal();
        logic [6:0] got;
        logic [1:0] rv;
        doReset();
        busL1.m0_rstrb_i = 1'b1;
        busL1.m0_wmask_i = 4'h3;
        busL1.m0_addr_i  = 32'h104;
        busL1.m0_wdata_i = 32'h0000_5A5A;
        #1;
        got = {busL1.m0_gnt_o, busL1.m1_gnt_o, busL1.s_wmask_o, busL1.s_rstrb_o};
        total++;
        if (got !== {2'b10, 4'h3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL ill_fwd: got %b want %b", got, {2'b10, 4'h3, 1'b0});
        end
        nextCycle();
        busL1.m0_rstrb_i = 1'b0;
        busL1.m0_wmask_i = 4'h0;
        for (int i = 1; i < 3; i++) begin
            #1;
            rv = {busL1.m0_rvalid_o, busL1.m1_rvalid_o};
            total++;
            if (rv !== 2'b00) begin
                bad++;
                $display("[TB] FAIL ill_norv%0d: got %b want 00", i, rv);
            end
            nextCycle();
        end
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_write_readback();
        test_round_robin();
        test_latency3();
        test_fixed_priority();
        test_reset_mid_read();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and sequencer for the shared SoC memory bus. It sits between two bus masters and the single upstream port of `mem_bus`:
- master 0: processor;
- master 1: boot loader / DMA engine.

It grants one transfer at a time, tracks the outstanding read for a fixed slave latency, and returns read data with a per-master valid pulse. Writes complete in the grant cycle; reads complete `RD_LAT` cycles later.

## Interface
Parameters:
- `RD_LAT`, 1: slave read latency in cycles, legal range 1..15.
- `ARB_MODE`, 0: 0 = round-robin; 1 = fixed priority, master 0 wins.

Ports (clock and reset: one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `m0_addr_i` / `m1_addr_i`  in  32  request address.
- `m0_rstrb_i` / `m1_rstrb_i`  in  1  read request; held until granted.
- `m0_wmask_i` / `m1_wmask_i`  in  4  byte write mask; nonzero = write request, held until granted.
- `m0_wdata_i` / `m1_wdata_i`  in  32  write data.
- `m0_gnt_o` / `m1_gnt_o`  out  1  request accepted this cycle (combinational).
- `m0_rvalid_o` / `m1_rvalid_o`  out  1  one-cycle pulse: read data valid.
- `m0_rdata_o` / `m1_rdata_o`  out  32  read data, equal to `s_rdata_i`; meaningful only with `rvalid`.
- `s_addr_o`  out  32  address to `mem_bus`.
- `s_rstrb_o`  out  1  read strobe to `mem_bus`.
- `s_wmask_o`  out  4  write mask to `mem_bus`.
- `s_wdata_o`  out  32  write data to `mem_bus`.
- `s_rdata_i`  in  32  read data from `mem_bus`, valid `RD_LAT` cycles after `s_rstrb_o`.

## Operation
- Request from master n: `req_n = mn_rstrb_i | (|mn_wmask_i)`.
- A master asserting both `rstrb` and a nonzero `wmask` is illegal. The arbiter forwards the write only, with `s_rstrb_o = 0`.
- States:
  - `IDLE`: grants allowed.
  - `RD_WAIT`: read outstanding; 4-bit counter `cnt` counts down from `RD_LAT-1`.
- Grant eligibility: in `IDLE`, or in `RD_WAIT` on the cycle `cnt == 0`. That is the completion cycle, so back-to-back pipelined grants are allowed.
- Winner selection:
  - Round-robin: a 1-bit `last` register; the master not equal to `last` wins when both request. `last` updates on every grant.
  - Fixed priority: master 0 always wins.
- On grant, the selected master's `addr`/`rstrb`/`wmask`/`wdata` drive `s_*` combinationally in the same cycle.
- When no grant occurs, `s_*` = 0.
- Granted read: record the owner in the `owner` register, load `cnt = RD_LAT-1`, and go to `RD_WAIT`.
- Granted write: no state change; the transfer is complete.
- `RD_WAIT` with `cnt == 0`:
  - pulse `m[owner]_rvalid_o`;
  - then go to `IDLE`, or reload `RD_WAIT` if a new read is granted in the same cycle.
- `RD_WAIT` with `cnt != 0`: decrement `cnt`; all gnt = 0.
- Both `m*_rdata_o` are wired to `s_rdata_i` continuously.

## Timing
- Reset values: all `gnt`/`rvalid`/`s_*` = 0; state `IDLE`; `cnt` = 0; `last` = 1 (master 0 wins first); `owner` = 0.
- Reset mid-read: the outstanding read is dropped with no `rvalid` pulse. Grants may resume on the cycle after `rst` deasserts.
- Write latency: 0 cycles. `gnt` and `s_wmask_o` appear in the same cycle T as the request, when eligible.
- Read: grant at cycle T; `rvalid` and data at T+`RD_LAT`.
- Read throughput: one per `RD_LAT` cycles. Write throughput: one per cycle.
- A write can be granted in the read-completion cycle. It does not disturb the returning `rvalid`.
- A request that drops before its grant is simply never serviced. Masters must hold requests; the arbiter keeps no queue.

## Structure
- Shared define file holds:
  - state encodings `ARB_IDLE` = 0, `ARB_RD_WAIT` = 1;
  - mode constants `ARB_RR` = 0, `ARB_FIXED` = 1;
  - default `ARB_RD_LAT`.
- Sub-module `rr_arb2`: 2-way round-robin/fixed-priority grant logic plus the `last` register.
- Top level holds the FSM, counter, `owner`, and muxes.
- `soc` instantiates `bus_arbiter` between the CPU / loader and `mem_bus`.

## Test plan
- Single write, `RD_LAT`=1:
  - stimulus: m0 `wmask`=4'hF, addr 0x100, wdata 0xDEADBEEF;
  - response: `m0_gnt_o`=1 and `s_wmask_o`=4'hF in the same cycle; the next-cycle readback via m0 `rstrb` yields `m0_rvalid_o` one cycle after grant with 0xDEADBEEF.
- Simultaneous reads, round-robin:
  - stimulus: m0 and m1 both assert `rstrb` at addr 0x10 and 0x20, continuously, from reset;
  - response: grant order m0, m1, m0, m1; each `rvalid` to the correct master exactly 1 cycle after its grant.
- `RD_LAT`=3:
  - stimulus: m1 read at T, m0 write requested at T+1;
  - response: m0 not granted at T+1 or T+2; `m1_rvalid_o` and `m0_gnt_o` both at T+3.
- `ARB_MODE`=1:
  - stimulus: both masters request continuously for 4 cycles;
  - response: m0 granted all 4 cycles; m1 gnt stays 0.
- Reset mid-read:
  - stimulus: `RD_LAT`=4, m0 read granted at T, `rst` high at T+2;
  - response: no `m0_rvalid_o` ever; all outputs 0 at T+3; a new m1 read granted on the first cycle after reset.
- Illegal request:
  - stimulus: m0 `rstrb`=1 and `wmask`=4'h3;
  - response: `s_wmask_o`=4'h3, `s_rstrb_o`=0, no `rvalid`.
